// File: rtl/card_shoe.sv
// Single-card dealer for the blackjack core: 52-card dealt-mask, LFSR-picked candidate, linear-probe collision fix.
// Build option CARD_SHOE_SEQUENTIAL_EN forces candidate 0 so a fresh deck deals in index order.
module card_shoe (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_drawReq,
    input  logic       i_shuffle,
    input  logic       i_seed,
    output logic       o_cardValid,
    output logic       o_busy,
    output logic       o_empty,
    output logic [5:0] o_cardIndex,
    output logic [3:0] o_cardRank,
    output logic [1:0] o_cardSuit,
    output logic [3:0] o_cardValue,
    output logic [5:0] o_cardsRemaining
);

    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [5:0]  DECK      = 6'd52;

    typedef enum logic [1:0] {IDLE, PROBE, PRESENT, EMPTY} state_t;

    state_t      state;
    logic [51:0] mask;
    logic [15:0] lfsr;
    logic [15:0] cnt;
    logic [15:0] lfsr_step;
    logic [5:0]  ptr;
    logic [5:0]  cand;
    logic [5:0]  base;
    logic [1:0]  suit_d;
    logic [3:0]  rank_d;
    logic [3:0]  value_d;
    logic        valid_q;

    assign lfsr_step = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ LFSR_MASK) : {1'b0, lfsr[15:1]};

`ifdef CARD_SHOE_SEQUENTIAL_EN
    assign cand = 6'd0;
`else
    logic [5:0] raw;
    assign raw  = lfsr[5:0];
    assign cand = (raw >= DECK) ? raw - DECK : raw;
`endif

    // Card decode of the probe pointer, latched only when the slot is claimed.
    always_comb begin
        if (ptr >= 6'd39) begin
            suit_d = 2'd3;
            base   = 6'd39;
        end else if (ptr >= 6'd26) begin
            suit_d = 2'd2;
            base   = 6'd26;
        end else if (ptr >= 6'd13) begin
            suit_d = 2'd1;
            base   = 6'd13;
        end else begin
            suit_d = 2'd0;
            base   = 6'd0;
        end
        rank_d  = 4'(ptr - base) + 4'd1;
        value_d = (rank_d > 4'd10) ? 4'd10 : rank_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state            <= IDLE;
            mask             <= '0;
            lfsr             <= LFSR_INIT;
            cnt              <= '0;
            ptr              <= '0;
            valid_q          <= 1'b0;
            o_busy           <= 1'b0;
            o_empty          <= 1'b0;
            o_cardIndex      <= '0;
            o_cardRank       <= 4'd1;
            o_cardSuit       <= '0;
            o_cardValue      <= 4'd1;
            o_cardsRemaining <= DECK;
        end else begin
            cnt     <= cnt + 16'd1;
            valid_q <= 1'b0;
            if (i_seed)
                lfsr <= (cnt == 16'd0) ? LFSR_INIT : cnt;
            else
                lfsr <= lfsr_step;

            unique case (state)
                IDLE: begin
                    if (i_shuffle) begin
                        mask             <= '0;
                        o_cardsRemaining <= DECK;
                    end else if (i_drawReq && o_cardsRemaining != 6'd0) begin
                        ptr    <= cand;
                        o_busy <= 1'b1;
                        state  <= PROBE;
                    end
                end
                PROBE: begin
                    if (i_shuffle) begin
                        mask             <= '0;
                        o_cardsRemaining <= DECK;
                        o_busy           <= 1'b0;
                        state            <= IDLE;
                    end else if (!mask[ptr]) begin
                        mask[ptr]   <= 1'b1;
                        o_cardIndex <= ptr;
                        o_cardRank  <= rank_d;
                        o_cardSuit  <= suit_d;
                        o_cardValue <= value_d;
                        valid_q     <= 1'b1;
                        state       <= PRESENT;
                    end else begin
                        ptr <= (ptr == 6'd51) ? 6'd0 : ptr + 6'd1;
                    end
                end
                PRESENT: begin
                    o_busy <= 1'b0;
                    if (i_shuffle) begin
                        mask             <= '0;
                        o_cardsRemaining <= DECK;
                        state            <= IDLE;
                    end else begin
                        o_cardsRemaining <= o_cardsRemaining - 6'd1;
                        if (o_cardsRemaining == 6'd1) begin
                            o_empty <= 1'b1;
                            state   <= EMPTY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                EMPTY: begin
                    if (i_shuffle) begin
                        mask             <= '0;
                        o_cardsRemaining <= DECK;
                        o_empty          <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A shuffle landing on the presentation cycle cancels that card's pulse.
    assign o_cardValid = valid_q & ~i_shuffle;

endmodule
